// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the register-file write-back front end.
// Holds the data width, the register address width, the write request
// payload (destination + data) and the x0 address constant.
package regfile_wb_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/wb_sync_fifo.sv
// Small synchronous FIFO buffering load results until they win the write port.
// Pointers carry one extra wrap bit: full when the wrap bits differ and the
// index bits match, empty when the pointers are equal.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   push_i, data_i    write request (ignored while full)
//   pop_i             consume the head entry (ignored while empty)
//   data_o            head entry
//   full_o, empty_o   occupancy flags
module wb_sync_fifo
  import regfile_wb_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter type         T     = wb_req_t
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned Aw = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Aw:0] wr_q, wr_d;
  logic [Aw:0] rd_q, rd_d;
  T            mem_q [Depth];
  logic        push_ok, pop_ok;

  assign full_o  = (wr_q[Aw] != rd_q[Aw]) && (wr_q[Aw-1:0] == rd_q[Aw-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q[Aw-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_ok) wr_d = wr_q + 1'b1;
    if (pop_ok)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: entries are only visible between valid pointers.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q[Aw-1:0]] <= data_i;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-side front end of the integer register file. Merges ALU results and
// buffered load results onto the single registered write port. ALU wins by
// default; a starvation counter forces a waiting load through after
// STARVE_LIMIT consecutive ALU grants. Writes to x0 are consumed with we_o=0.
// Optional macro WB_SCOREBOARD_EN adds a busy bitmap of registers with
// outstanding loads; without it busy_o is 0 and the issue inputs are ignored.
// Ports:
//   clk, reset                           clock, asynchronous active-high reset
//   alu_valid_i/alu_ready_o/alu_rd_i/alu_data_i   ALU result handshake
//   ld_valid_i/ld_ready_o/ld_rd_i/ld_data_i       load result handshake
//   ld_issue_i/ld_issue_rd_i             load leaving decode (marks rd busy)
//   busy_o                               pending-load bitmap
//   we_o/destReg_o/writeData_o           registered regfile write port
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int unsigned LOAD_FIFO_DEPTH = 2,
  parameter int unsigned STARVE_LIMIT    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid_i,
  output logic                  alu_ready_o,
  input  logic [REG_ADDR_W-1:0] alu_rd_i,
  input  logic [XLEN-1:0]       alu_data_i,
  input  logic                  ld_valid_i,
  output logic                  ld_ready_o,
  input  logic [REG_ADDR_W-1:0] ld_rd_i,
  input  logic [XLEN-1:0]       ld_data_i,
  input  logic                  ld_issue_i,
  input  logic [REG_ADDR_W-1:0] ld_issue_rd_i,
  output logic [XLEN-1:0]       busy_o,
  output logic                  we_o,
  output logic [REG_ADDR_W-1:0] destReg_o,
  output logic [XLEN-1:0]       writeData_o
);

  localparam int unsigned CntW = ($clog2(STARVE_LIMIT + 1) < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] LimitC = CntW'(STARVE_LIMIT);

  wb_req_t ld_req, head, win;
  logic    fifo_full, fifo_empty;
  logic    force_ld, grant_ld, grant_alu;

  logic [CntW-1:0]       starve_q, starve_d;
  logic                  we_q, we_d;
  logic [REG_ADDR_W-1:0] dest_q, dest_d;
  logic [XLEN-1:0]       data_q, data_d;

  assign ld_req = '{rd: ld_rd_i, data: ld_data_i};

  wb_sync_fifo #(
    .Depth (LOAD_FIFO_DEPTH),
    .T     (wb_req_t)
  ) u_ld_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (ld_valid_i),
    .data_i  (ld_req),
    .pop_i   (grant_ld),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Arbitration works only on registered state, so a load pushed this cycle
  // cannot be granted before the next edge.
  assign force_ld    = !fifo_empty && (starve_q == LimitC);
  assign grant_ld    = !fifo_empty && (!alu_valid_i || force_ld);
  assign grant_alu   = alu_valid_i && !grant_ld;
  assign alu_ready_o = !force_ld;
  assign ld_ready_o  = !fifo_full;

  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || grant_ld) begin
      starve_d = '0;
    end else if (grant_alu && (starve_q != LimitC)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_comb begin
    win    = grant_ld ? head : '{rd: alu_rd_i, data: alu_data_i};
    we_d   = 1'b0;
    dest_d = dest_q;
    data_d = data_q;
    if (grant_ld || grant_alu) begin
      // A grant to x0 still consumes the result, it just doesn't write.
      we_d   = (win.rd != REG_X0);
      dest_d = win.rd;
      data_d = win.data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
      we_q     <= 1'b0;
      dest_q   <= '0;
      data_q   <= '0;
    end else begin
      starve_q <= starve_d;
      we_q     <= we_d;
      dest_q   <= dest_d;
      data_q   <= data_d;
    end
  end

  assign we_o        = we_q;
  assign destReg_o   = dest_q;
  assign writeData_o = data_q;

`ifdef WB_SCOREBOARD_EN
  logic [XLEN-1:0] busy_q, busy_d;

  // Clear before set so a same-cycle re-issue keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (grant_ld) busy_d[head.rd] = 1'b0;
    if (ld_issue_i && (ld_issue_rd_i != REG_X0)) busy_d[ld_issue_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_o = busy_q;
`else
  logic unused_issue;
  assign unused_issue = ^{ld_issue_i, ld_issue_rd_i};
  assign busy_o       = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int unsigned Depth = 2;
  localparam int unsigned Limit = 3;
`ifdef WB_SCOREBOARD_EN
  localparam bit SbEn = 1'b1;
`else
  localparam bit SbEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid_i, ld_valid_i, ld_issue_i;
  logic        alu_ready_o, ld_ready_o, we_o;
  logic [4:0]  alu_rd_i, ld_rd_i, ld_issue_rd_i, destReg_o;
  logic [31:0] alu_data_i, ld_data_i, busy_o, writeData_o;

  regfile_wb_arbiter #(
    .LOAD_FIFO_DEPTH (Depth),
    .STARVE_LIMIT    (Limit)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .alu_valid_i   (alu_valid_i),
    .alu_ready_o   (alu_ready_o),
    .alu_rd_i      (alu_rd_i),
    .alu_data_i    (alu_data_i),
    .ld_valid_i    (ld_valid_i),
    .ld_ready_o    (ld_ready_o),
    .ld_rd_i       (ld_rd_i),
    .ld_data_i     (ld_data_i),
    .ld_issue_i    (ld_issue_i),
    .ld_issue_rd_i (ld_issue_rd_i),
    .busy_o        (busy_o),
    .we_o          (we_o),
    .destReg_o     (destReg_o),
    .writeData_o   (writeData_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: load queue of {rd, data}, starvation count, outputs.
  logic [36:0] q_m[$];
  int          starve_m;
  logic        exp_we;
  logic [4:0]  exp_dest;
  logic [31:0] exp_data;
  logic [31:0] busy_m;
  bit          alu_acc, ld_acc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q_m.delete();
    starve_m = 0;
    exp_we   = 1'b0;
    exp_dest = '0;
    exp_data = '0;
    busy_m   = '0;
  endtask

  task automatic drive_idle();
    alu_valid_i   = 1'b0;
    alu_rd_i      = '0;
    alu_data_i    = '0;
    ld_valid_i    = 1'b0;
    ld_rd_i       = '0;
    ld_data_i     = '0;
    ld_issue_i    = 1'b0;
    ld_issue_rd_i = '0;
  endtask

  // One clock cycle: drive, check readies, clock, advance model, check outputs.
  task automatic step(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                      input bit lv, input logic [4:0] lrd, input logic [31:0] ldd,
                      input bit iv, input logic [4:0] ird);
    bit          frc, gl, ga, lrdy, was_empty;
    logic [36:0] h;
    @(negedge clk);
    alu_valid_i = av; alu_rd_i = ard; alu_data_i = ad;
    ld_valid_i = lv; ld_rd_i = lrd; ld_data_i = ldd;
    ld_issue_i = iv; ld_issue_rd_i = ird;
    #1;
    was_empty = (q_m.size() == 0);
    frc  = !was_empty && (starve_m == Limit);
    lrdy = (q_m.size() < Depth);
    check_eq("alu_ready", alu_ready_o, !frc);
    check_eq("ld_ready", ld_ready_o, lrdy);
    gl = !was_empty && (!av || frc);
    ga = av && !gl;
    alu_acc = ga;
    ld_acc  = lv && lrdy;
    @(posedge clk);
    exp_we = 1'b0;
    if (gl) begin
      h = q_m.pop_front();
      exp_we = (h[36:32] != 0);
      exp_dest = h[36:32];
      exp_data = h[31:0];
      if (SbEn) busy_m[h[36:32]] = 1'b0;
    end else if (ga) begin
      exp_we = (ard != 0);
      exp_dest = ard;
      exp_data = ad;
    end
    if (was_empty || gl) starve_m = 0;
    else if (ga && starve_m < Limit) starve_m++;
    if (ld_acc) q_m.push_back({lrd, ldd});
    if (SbEn && iv && ird != 0) busy_m[ird] = 1'b1;
    #1;
    check_eq("we", we_o, exp_we);
    check_eq("dest", destReg_o, exp_dest);
    check_eq("data", writeData_o, exp_data);
    check_eq("busy", busy_o, busy_m);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bit          av, lv;
    logic [4:0]  ard, lrd;
    logic [31:0] ad, ldd;
    int          lsent, lwritten, cyc;

    reset = 1'b1;
    drive_idle();
    model_reset();
    #12;
    check_eq("rst_we", we_o, 0);
    check_eq("rst_dest", destReg_o, 0);
    check_eq("rst_data", writeData_o, 0);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_alu_ready", alu_ready_o, 1);
    check_eq("rst_ld_ready", ld_ready_o, 1);
    @(negedge clk);
    reset = 1'b0;

    // ALU only: back-to-back writes, one cycle after each accept.
    step(1, 5, 32'h11, 0, 0, 0, 0, 0);
    check_eq("aluonly_we0", we_o, 1);
    step(1, 6, 32'h22, 0, 0, 0, 0, 0);
    check_eq("aluonly_d1", writeData_o, 32'h11 + 32'h11);
    step(1, 7, 32'h33, 0, 0, 0, 0, 0);
    check_eq("aluonly_dest2", destReg_o, 7);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("aluonly_idle_we", we_o, 0);

    // Starvation: ALU every cycle, one load pushed alongside the first.
    step(1, 1, 32'hA1, 1, 9, 32'hDEAD, 0, 0);
    step(1, 2, 32'hA2, 0, 0, 0, 0, 0);
    step(1, 3, 32'hA3, 0, 0, 0, 0, 0);
    step(1, 4, 32'hA4, 0, 0, 0, 0, 0);
    check_eq("starve_alu3", writeData_o, 32'hA4);
    step(1, 5, 32'hA5, 0, 0, 0, 0, 0);
    check_eq("starve_stalled", alu_acc, 0);
    check_eq("starve_ld_dest", destReg_o, 9);
    check_eq("starve_ld_data", writeData_o, 32'hDEAD);
    step(1, 5, 32'hA5, 0, 0, 0, 0, 0);
    check_eq("starve_held_alu", writeData_o, 32'hA5);

    // FIFO full and pointer wrap: ALU saturating, 10 loads to x20 in order.
    av = 1; ard = 3; ad = 32'h5000;
    lsent = 0; lwritten = 0; cyc = 0;
    while (lwritten < 10 && cyc < 200) begin
      lv = (lsent < 10);
      step(av, ard, ad, lv, 20, 32'h100 + lsent, 0, 0);
      if (alu_acc) ad++;
      if (ld_acc) lsent++;
      if (we_o && destReg_o == 20) begin
        check_eq("fifo_order", writeData_o, 32'h100 + lwritten);
        lwritten++;
      end
      cyc++;
    end
    check_eq("fifo_load_count", lwritten, 10);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);

    // x0 handling.
    step(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 1, 0);
    check_eq("x0_we", we_o, 0);
    check_eq("x0_busy0", busy_o[0], 0);

    // Scoreboard: same-cycle set wins over clear, later writeback clears.
    step(0, 0, 0, 0, 0, 0, 1, 4);
    check_eq("sb_set", busy_o[4], SbEn);
    step(0, 0, 0, 1, 4, 32'h44, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 4);
    check_eq("sb_wb_dest", destReg_o, 4);
    check_eq("sb_set_wins", busy_o[4], SbEn);
    step(0, 0, 0, 1, 4, 32'h45, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("sb_cleared", busy_o[4], 0);

    // Randomized traffic with producers holding unaccepted results.
    av = 0; lv = 0; ard = 0; lrd = 0; ad = 0; ldd = 0;
    for (int i = 0; i < 400; i++) begin
      if (!av || alu_acc) begin
        av  = ($urandom_range(0, 3) != 0);
        ard = 5'($urandom_range(0, 31));
        ad  = $urandom;
      end
      if (!lv || ld_acc) begin
        lv  = ($urandom_range(0, 2) == 0);
        lrd = 5'($urandom_range(0, 31));
        ldd = $urandom;
      end
      step(av, ard, ad, lv, lrd, ldd, ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)));
    end
    repeat (10) step(0, 0, 0, 0, 0, 0, 0, 0);

    // Async reset with two loads buffered and a write in flight.
    step(1, 3, 32'h77, 1, 21, 32'hD1, 1, 21);
    step(1, 3, 32'h78, 1, 22, 32'hD2, 1, 22);
    check_eq("ar_pre_we", we_o, 1);
    @(negedge clk);
    drive_idle();
    #1 reset = 1'b1;
    #1;
    check_eq("ar_we", we_o, 0);
    check_eq("ar_dest", destReg_o, 0);
    check_eq("ar_data", writeData_o, 0);
    check_eq("ar_busy", busy_o, 0);
    check_eq("ar_ld_ready", ld_ready_o, 1);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0);
      check_eq("ar_no_stale", we_o, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-side front end of the integer register file: merges ALU results and load results into the single regfile write port (`we`/`destReg`/`writeData`). ALU results have priority. Load results are buffered in a small FIFO, and a starvation counter guarantees they eventually win a slot. An optional scoreboard tracks registers with outstanding loads, so decode can stall on them.

## Interface
Parameters:
- `LOAD_FIFO_DEPTH`, default 2: load-result buffer entries; power of two, ≥2.
- `STARVE_LIMIT`, default 3: consecutive ALU grants while a load waits before the load is forced.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `alu_valid_i` in 1: ALU result present.
- `alu_ready_o` out 1: ALU result accepted this cycle when high with valid.
- `alu_rd_i` in 5: ALU destination register.
- `alu_data_i` in 32: ALU result.
- `ld_valid_i` in 1: load result present.
- `ld_ready_o` out 1: load result accepted into the FIFO when high with valid.
- `ld_rd_i` in 5: load destination register.
- `ld_data_i` in 32: load data.
- `ld_issue_i` in 1: load leaving decode; marks `ld_issue_rd_i` busy.
- `ld_issue_rd_i` in 5: destination of the issuing load.
- `busy_o` out 32: bit r set means r has a pending load.
- `we_o` out 1: regfile write enable (registered).
- `destReg_o` out 5: regfile write address (registered).
- `writeData_o` out 32: regfile write data (registered).

## Operation
- **Load FIFO:** push on `ld_valid_i && ld_ready_o`. `ld_ready_o = !full`, so a push is never accepted while full, even if a pop happens the same cycle. Pointers are log2(DEPTH)+1 bits wide and wrap naturally; full means MSBs differ and LSBs are equal.
- **Grant, evaluated per cycle on registered state:**
  - `force = !empty && starve_cnt == STARVE_LIMIT`.
  - Grant load head if `!empty && (!alu_valid_i || force)`.
  - Otherwise grant ALU if `alu_valid_i`.
  - Otherwise no grant.
- **Ready:** `alu_ready_o = !force`, combinational. An ALU result offered while forced is held by the producer.
- **Starvation counter `starve_cnt`:**
  - increments on an ALU grant while the FIFO is non-empty;
  - clears on a load grant or when the FIFO is empty;
  - saturates at `STARVE_LIMIT`.
- **Output register:** on a grant, `destReg_o`/`writeData_o` take the winner's rd and data.
  - `we_o` = 1 if rd ≠ 0; a grant to x0 is consumed with `we_o` = 0.
  - With no grant, `we_o` = 0 and `destReg_o`/`writeData_o` hold their previous values.
- **Scoreboard:**
  - `ld_issue_i` with rd ≠ 0 sets `busy_o[rd]`.
  - A load grant clears `busy_o[rd]`.
  - If set and clear hit the same register in the same cycle, set wins.
  - Bit 0 is always 0.

## Timing
- Reset values: `we_o` = 0, `destReg_o` = 0, `writeData_o` = 0, `busy_o` = 0, FIFO empty, `starve_cnt` = 0.
- After reset: `alu_ready_o` = 1, `ld_ready_o` = 1.
- ALU latency: accepted at edge N, so `we_o` is high for the cycle following edge N.
- Load latency: pushed at edge N, earliest grant at edge N+1, so `we_o` is high after N+1. A load always spends at least one cycle in the FIFO.
- Worst-case load wait with a continuously valid ALU: `STARVE_LIMIT` + 1 cycles per FIFO entry ahead of it.
- Reset mid-operation: FIFO contents and busy bits are discarded; an in-flight `we_o` drops immediately.
- One write per cycle, maximum; ALU and load are never both granted.

## Configuration
- Macro `WB_SCOREBOARD_EN`.
- Defined: scoreboard behaves as above.
- Undefined: no scoreboard flops, `busy_o` tied to 0, `ld_issue_i`/`ld_issue_rd_i` ignored. Arbitration is unchanged.

## Structure
- Package `regfile_wb_pkg` holds:
  - `XLEN` = 32 and `REG_ADDR_W` = 5;
  - typedef `wb_req_t` {rd, data};
  - constant `REG_X0` = 0.
- Sub-module `wb_sync_fifo`, parameterised by depth and the `wb_req_t` payload, with `full`/`empty`. Arbiter, counter, output register and scoreboard stay in the top module.

## Test plan
- **ALU only:** 3 back-to-back ALU results (x5=0x11, x6=0x22, x7=0x33). Expect `we_o` high 3 consecutive cycles with matching dest/data, one cycle after each accept, and `alu_ready_o` stays 1.
- **Starvation:** `STARVE_LIMIT`=3, ALU valid every cycle, one load x9=0xDEAD pushed. Expect 3 ALU writes, then `alu_ready_o` = 0 for one cycle, then the x9 write; the stalled ALU result is written on the next cycle.
- **FIFO full:** ALU saturating, 3 loads offered. Expect `ld_ready_o` = 0 after 2 pushes, the third accepted only after the first pop, and the pointer wrap checked over 10 loads with in-order data.
- **x0 handling:** ALU to x0 with 0xFFFF_FFFF and `ld_issue` to x0. Expect `we_o` = 0 and `busy_o[0]` = 0.
- **Scoreboard:** issue load x4 and `busy_o[4]` = 1. Write back x4 while a new load issue to x4 occurs in the same cycle: `busy_o[4]` stays 1. A later writeback clears it.
- **Async reset:** assert `reset` mid-stream with 2 loads buffered. Outputs go to 0 without waiting for a clock edge, and after release no stale load writes occur.
